bus_fabric: RTL and testbench

BUS_FABRIC -- requirements
Module: bus_fabric

---
 rtl/bus_pkg.sv | 11 +
 rtl/bus_fabric_if.sv | 12 +
 rtl/bus_addr_decode.sv | 21 ++
 rtl/bus_fabric.sv | 97 +++++++++
 tb/tb_bus_fabric.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/bus_pkg.sv
// bus_pkg: shared FSM encoding, error codes and defaults for the bus fabric
package bus_pkg;
  typedef enum logic [1:0] {IDLE, RD_WAIT, WR_WAIT, ERR_RESP} state_t;
  localparam logic [1:0] ERR_MISS = 2'b01;
  localparam logic [1:0] ERR_TMO  = 2'b10;
  localparam logic [1:0] ERR_COLL = 2'b11;
  localparam logic [31:0] DEF_ERR_DATA = 32'hDEAD_BEEF;
  function automatic int idx_w(int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/bus_fabric_if.sv
// bus_fabric_if: CPU-side request/response bus of the fabric
interface bus_fabric_if;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [3:0]  m_wmask;
  logic        m_rstrb;
  logic [31:0] m_rdata;
  logic        m_rbusy;
  logic        m_wbusy;
  modport master (output m_addr, m_wdata, m_wmask, m_rstrb, input m_rdata, m_rbusy, m_wbusy);
  modport slave  (input m_addr, m_wdata, m_wmask, m_rstrb, output m_rdata, m_rbusy, m_wbusy);
endinterface

// File: rtl/bus_addr_decode.sv
// bus_addr_decode: base/mask address match, lowest index wins on overlap
module bus_addr_decode import bus_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {4{32'hFF00_0000}}
) (
  input  logic [31:0]                    addr,
  output logic                           hit,
  output logic [idx_w(NUM_SLAVES)-1:0]   idx
);
  localparam int IW = idx_w(NUM_SLAVES);
  always_comb begin
    hit = 1'b0;
    idx = '0;
    for (int i = NUM_SLAVES - 1; i >= 0; i--)
      if ((addr & SLAVE_MASK[32*i +: 32]) == SLAVE_BASE[32*i +: 32]) begin
        hit = 1'b1;
        idx = IW'(i);
      end
  end
endmodule

// File: rtl/bus_fabric.sv
// bus_fabric: single-master to NUM_SLAVES fabric with timeout and sticky error capture
module bus_fabric import bus_pkg::*; #(
  parameter int NUM_SLAVES = 4,
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_BASE = {32'h0300_0000, 32'h0200_0000, 32'h0100_0000, 32'h0000_0000},
  parameter logic [32*NUM_SLAVES-1:0] SLAVE_MASK = {4{32'hFF00_0000}},
  parameter int TIMEOUT = 255,
  parameter logic [31:0] ERR_DATA = DEF_ERR_DATA
) (
  input  logic                      clk,
  input  logic                      reset_n,
  bus_fabric_if.slave               m,
  output logic [31:0]               s_addr,
  output logic [31:0]               s_wdata,
  output logic [NUM_SLAVES-1:0]     s_rstrb,
  output logic [4*NUM_SLAVES-1:0]   s_wmask,
  input  logic [32*NUM_SLAVES-1:0]  s_rdata,
  input  logic [NUM_SLAVES-1:0]     s_rvalid,
  input  logic [NUM_SLAVES-1:0]     s_wready,
  input  logic                      err_clr,
  output logic                      err_irq,
  output logic [31:0]               err_addr,
  output logic [1:0]                err_code
);
  localparam int IW = idx_w(NUM_SLAVES);
  state_t state, state_d;
  logic dec_hit, rd_op, wr_req, req, done, tmo, err_set;
  logic [IW-1:0] dec_idx, idx;
  logic [15:0] cnt;
  logic [1:0] err_new;
  logic [31:0] err_at;
  bus_addr_decode #(.NUM_SLAVES(NUM_SLAVES), .SLAVE_BASE(SLAVE_BASE), .SLAVE_MASK(SLAVE_MASK))
    u_dec (.addr(m.m_addr), .hit(dec_hit), .idx(dec_idx));
  assign wr_req = |m.m_wmask;
  assign req = wr_req || m.m_rstrb;
  assign m.m_rbusy = state == RD_WAIT || (state == ERR_RESP && rd_op);
  assign m.m_wbusy = state == WR_WAIT || (state == ERR_RESP && !rd_op);
  always_comb begin
    state_d = state;
    err_set = 1'b0;
    err_new = ERR_MISS;
    err_at  = m.m_addr;
    done    = 1'b0;
    tmo     = 1'b0;
    case (state)
      IDLE: if (req) begin
        state_d = !dec_hit ? ERR_RESP : wr_req ? WR_WAIT : RD_WAIT;
        err_set = !dec_hit || (wr_req && m.m_rstrb);
        err_new = (wr_req && m.m_rstrb) ? ERR_COLL : ERR_MISS;
      end
      RD_WAIT, WR_WAIT: begin
        done    = state == RD_WAIT ? s_rvalid[idx] : s_wready[idx];
        tmo     = !done && cnt == 16'(TIMEOUT - 1);
        state_d = (done || tmo) ? IDLE : state;
        err_set = tmo;
        err_new = ERR_TMO;
        err_at  = s_addr;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge reset_n)
    if (!reset_n) begin
      state    <= IDLE;
      m.m_rdata <= '0;
      s_rstrb  <= '0;
      s_wmask  <= '0;
      s_addr   <= '0;
      s_wdata  <= '0;
      cnt      <= '0;
      idx      <= '0;
      rd_op    <= 1'b0;
      err_irq  <= 1'b0;
      err_addr <= '0;
      err_code <= '0;
    end else begin
      state   <= state_d;
      s_rstrb <= '0;
      s_wmask <= '0;
      cnt     <= (state == RD_WAIT || state == WR_WAIT) ? cnt + 16'd1 : '0;
      if (state == IDLE && req) begin
        s_addr  <= m.m_addr;
        s_wdata <= m.m_wdata;
        idx     <= dec_idx;
        rd_op   <= !wr_req;
        if (dec_hit && wr_req) s_wmask[dec_idx*4 +: 4] <= m.m_wmask;
        else if (dec_hit) s_rstrb[dec_idx] <= 1'b1;
        else if (!wr_req) m.m_rdata <= ERR_DATA;
      end
      if (state == RD_WAIT && (done || tmo)) m.m_rdata <= done ? s_rdata[idx*32 +: 32] : ERR_DATA;
      // a fresh error overrides a simultaneous clear
      if (err_set && (!err_irq || err_clr)) begin
        err_irq  <= 1'b1;
        err_addr <= err_at;
        err_code <= err_new;
      end else if (err_clr) err_irq <= 1'b0;
    end
endmodule

// File: tb/tb_bus_fabric.sv
// tb_bus_fabric: directed checks of decode, handshakes, timeout, errors and reset
module tb_bus_fabric;
  logic clk = 0, reset_n = 0, err_clr = 0, err_irq;
  logic [31:0] s_addr, s_wdata, err_addr;
  logic [3:0] s_rstrb, s_rvalid = 0, s_wready = 0;
  logic [15:0] s_wmask;
  logic [127:0] s_rdata = '0;
  logic [1:0] err_code;
  int n_chk = 0, n_pass = 0;
  bus_fabric_if bif();
  bus_fabric #(.TIMEOUT(4)) dut (
    .clk(clk), .reset_n(reset_n), .m(bif), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rstrb(s_rstrb), .s_wmask(s_wmask), .s_rdata(s_rdata), .s_rvalid(s_rvalid),
    .s_wready(s_wready), .err_clr(err_clr), .err_irq(err_irq), .err_addr(err_addr),
    .err_code(err_code));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  task automatic req(input logic [31:0] a, input logic [3:0] wm, input logic rs);
    bif.m_addr = a;
    bif.m_wdata = 32'hA5A5_0000 ^ a;
    bif.m_wmask = wm;
    bif.m_rstrb = rs;
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    int n;
    req(32'h0, 4'h0, 1'b0);
    step;
    step;
    check("rst_rdata", bif.m_rdata, 32'h0);
    check("rst_busy", {30'b0, bif.m_rbusy, bif.m_wbusy}, 32'h0);
    check("rst_irq", {31'b0, err_irq}, 32'h0);
    check("rst_strb", {12'b0, s_wmask, s_rstrb}, 32'h0);
    reset_n = 1;
    // read slave 0, answer in the strobe cycle
    req(32'h0000_0010, 4'h0, 1'b1);
    step;
    check("rd0_strb", {28'b0, s_rstrb}, 32'h1);
    check("rd0_busy", {31'b0, bif.m_rbusy}, 32'h1);
    check("rd0_saddr", s_addr, 32'h0000_0010);
    req(32'h0, 4'h0, 1'b0);
    s_rvalid = 4'b0001;
    s_rdata[31:0] = 32'h1234_5678;
    step;
    s_rvalid = 0;
    check("rd0_busy_end", {31'b0, bif.m_rbusy}, 32'h0);
    check("rd0_strb_end", {28'b0, s_rstrb}, 32'h0);
    check("rd0_data", bif.m_rdata, 32'h1234_5678);
    // write slave 1, wrong-slave ready ignored, ready on third busy cycle
    req(32'h0100_0004, 4'b0011, 1'b0);
    step;
    check("wr1_mask", {16'b0, s_wmask}, 32'h0030);
    check("wr1_rstrb", {28'b0, s_rstrb}, 32'h0);
    check("wr1_busy1", {31'b0, bif.m_wbusy}, 32'h1);
    check("wr1_wdata", s_wdata, 32'hA5A5_0000 ^ 32'h0100_0004);
    req(32'h0, 4'h0, 1'b0);
    s_wready = 4'b0001;
    step;
    s_wready = 0;
    check("wr1_mask_once", {16'b0, s_wmask}, 32'h0);
    check("wr1_busy2", {31'b0, bif.m_wbusy}, 32'h1);
    step;
    check("wr1_busy3", {31'b0, bif.m_wbusy}, 32'h1);
    s_wready = 4'b0010;
    step;
    s_wready = 0;
    check("wr1_done", {31'b0, bif.m_wbusy}, 32'h0);
    check("wr1_rdata_hold", bif.m_rdata, 32'h1234_5678);
    // decode miss on read
    req(32'h0700_0000, 4'h0, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    check("miss_rstrb", {28'b0, s_rstrb}, 32'h0);
    check("miss_busy", {31'b0, bif.m_rbusy}, 32'h1);
    check("miss_rdata", bif.m_rdata, 32'hDEAD_BEEF);
    check("miss_irq", {31'b0, err_irq}, 32'h1);
    check("miss_code", {30'b0, err_code}, 32'h1);
    check("miss_addr", err_addr, 32'h0700_0000);
    step;
    check("miss_busy_end", {31'b0, bif.m_rbusy}, 32'h0);
    err_clr = 1;
    step;
    err_clr = 0;
    check("clr_irq", {31'b0, err_irq}, 32'h0);
    // slave 2 never answers
    req(32'h0200_0008, 4'h0, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    check("tmo_strb", {28'b0, s_rstrb}, 32'h4);
    n = 0;
    while (bif.m_rbusy && n < 20) begin
      n++;
      step;
    end
    check("tmo_busy_cycles", n, 4);
    check("tmo_rdata", bif.m_rdata, 32'hDEAD_BEEF);
    check("tmo_code", {30'b0, err_code}, 32'h2);
    check("tmo_addr", err_addr, 32'h0200_0008);
    req(32'h0900_0000, 4'h0, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    step;
    check("first_err_addr", err_addr, 32'h0200_0008);
    check("first_err_code", {30'b0, err_code}, 32'h2);
    err_clr = 1;
    step;
    err_clr = 0;
    check("tmo_clr", {31'b0, err_irq}, 32'h0);
    // read+write collision at slave 3
    req(32'h0300_0000, 4'b1111, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    check("coll_mask", {16'b0, s_wmask}, 32'hF000);
    check("coll_rstrb", {28'b0, s_rstrb}, 32'h0);
    check("coll_busy", {30'b0, bif.m_rbusy, bif.m_wbusy}, 32'h1);
    check("coll_code", {30'b0, err_code}, 32'h3);
    s_wready = 4'b1000;
    step;
    s_wready = 0;
    check("coll_done", {31'b0, bif.m_wbusy}, 32'h0);
    // new error beats simultaneous clear
    err_clr = 1;
    req(32'h0A00_0000, 4'b0001, 1'b0);
    step;
    err_clr = 0;
    req(32'h0, 4'h0, 1'b0);
    check("clr_race_irq", {31'b0, err_irq}, 32'h1);
    check("clr_race_code", {30'b0, err_code}, 32'h1);
    check("clr_race_addr", err_addr, 32'h0A00_0000);
    check("wmiss_wbusy", {31'b0, bif.m_wbusy}, 32'h1);
    step;
    // reset in the middle of a read
    req(32'h0100_0000, 4'h0, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    check("rst_mid_busy_pre", {31'b0, bif.m_rbusy}, 32'h1);
    #2 reset_n = 0;
    #1;
    check("rst_mid_busy", {31'b0, bif.m_rbusy}, 32'h0);
    check("rst_mid_rdata", bif.m_rdata, 32'h0);
    check("rst_mid_saddr", s_addr, 32'h0);
    check("rst_mid_err", {err_irq, err_code, 29'b0} | err_addr, 32'h0);
    check("rst_mid_strb", {12'b0, s_wmask, s_rstrb}, 32'h0);
    reset_n = 1;
    req(32'h0000_0020, 4'h0, 1'b1);
    step;
    req(32'h0, 4'h0, 1'b0);
    check("post_rst_strb", {28'b0, s_rstrb}, 32'h1);
    s_rvalid = 4'b0001;
    s_rdata[31:0] = 32'hCAFE_F00D;
    step;
    s_rvalid = 0;
    check("post_rst_data", bif.m_rdata, 32'hCAFE_F00D);
    check("post_rst_busy", {31'b0, bif.m_rbusy}, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
